// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control unit: sequences fetch/decode/execute/memory/writeback over a shared ALU and unified memory.
// Outputs are decoded from the registered state plus the current inputs; memory states hold until mem_ready.
module multicycle_control_fsm #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit ENABLE_JAL    = 1'b1,
   parameter bit ILLEGAL_HALT  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       negative,
   input  logic       overflow,
   input  logic       carry,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_req,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal,
   output logic       halted
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_HALT
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b010;

   state_t     state_q, state_d;
   logic       ready;
   logic       dec_illegal;
   state_t     dec_next;
   logic       taken;
   logic [2:0] alu_dec;

   assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign halted = (state_q == S_HALT);

   // Opcode/funct3 decode used only when leaving DECODE
   always_comb begin
      dec_illegal = 1'b0;
      dec_next    = S_FETCH;
      case (op)
         OP_LOAD, OP_STORE: dec_next = S_MEMADR;
         OP_R: begin
            dec_illegal = (funct3 == 3'b011);
            dec_next    = S_EXECR;
         end
         OP_I: begin
            dec_illegal = (funct3 == 3'b011);
            dec_next    = S_EXECI;
         end
         OP_B: begin
            dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            dec_next    = S_BRANCH;
         end
         OP_JAL: begin
            dec_illegal = !ENABLE_JAL;
            dec_next    = S_JAL;
         end
         OP_LUI:  dec_next    = S_LUI;
         default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
   end

   always_comb begin
      alu_dec = ALU_ADD;
      case (funct3)
         3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_dec = 3'b001;
         3'b010:  alu_dec = 3'b011;
         3'b100:  alu_dec = 3'b100;
         3'b101:  alu_dec = 3'b101;
         3'b110:  alu_dec = 3'b110;
         3'b111:  alu_dec = 3'b111;
         default: alu_dec = ALU_ADD;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = !(negative ^ overflow);
         3'b110:  taken = !carry;
         3'b111:  taken = carry;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         OP_STORE: imm_src = 3'b001;
         OP_B:     imm_src = 3'b010;
         OP_JAL:   imm_src = 3'b011;
         OP_LUI:   imm_src = 3'b100;
         default:  imm_src = 3'b000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      reg_write   = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = ready;
            pc_write   = ready;
            if (ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b01;
            illegal    = dec_illegal;
            instr_done = dec_illegal && !ILLEGAL_HALT;
            state_d    = dec_next;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            adr_src    = 1'b1;
            instr_done = ready;
            if (ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_dec;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_dec;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            pc_write    = taken;
            instr_done  = 1'b1;
            state_d     = S_FETCH;
         end
         // Link value PC+4 is formed here and written back in ALUWB
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_d   = S_ALUWB;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
      if (rst) begin
         pc_write   = 1'b0;
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed per-cycle vector table for multicycle_control_fsm, plus wait-state latency sequences.
module tb_multicycle_control_fsm;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] LU  = 7'b0110111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct packed {
      logic       pcw, adr, req, wr, irw;
      logic [1:0] rs, sa, sb;
      logic [2:0] imm, alu;
      logic       rw, done, ill, hlt;
   } out_t;

   typedef struct {
      string      name;
      logic       rst;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [3:0] flags;   // {zero, negative, overflow, carry}
      logic       rdy;
      out_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst, funct7b5, zero, negative, overflow, carry, mem_ready;
   logic [6:0] op;
   logic [2:0] funct3;
   logic pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, instr_done, illegal, halted;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src, alu_control;
   out_t act;

   int n_chk = 0;
   int n_fail = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
      .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_control(alu_control), .reg_write(reg_write), .instr_done(instr_done),
      .illegal(illegal), .halted(halted)
   );

   assign act = {pc_write, adr_src, mem_req, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, alu_control, reg_write, instr_done, illegal, halted};

   function automatic out_t e(input logic pcw, adr, req, wr, irw, input logic [1:0] rs, sa, sb,
                              input logic [2:0] imm, alu, input logic rw, done, ill, hlt);
      out_t o;
      o = {pcw, adr, req, wr, irw, rs, sa, sb, imm, alu, rw, done, ill, hlt};
      return o;
   endfunction

   task automatic add(input string nm, input logic r, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic [3:0] fl, input logic rdy, input out_t ex);
      vec_t v;
      v.name = nm; v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.flags = fl; v.rdy = rdy; v.exp = ex;
      vq.push_back(v);
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end
   endtask

   initial begin
      rst = 1'b1; op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
      {zero, negative, overflow, carry} = 4'b0000; mem_ready = 1'b1;

      // Reset held; state is FETCH after the first edge, enables forced low
      for (int i = 0; i < 3; i++)
         add("rst_hold", 1, LW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      // lw, zero wait
      add("lw_fetch",   0, LW, 3'b010, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      add("lw_decode",  0, LW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0,0,0));
      add("lw_memadr",  0, LW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0,0,0));
      add("lw_memread", 0, LW, 3'b010, 0, 4'h0, 1, e(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,0,0));
      add("lw_memwb",   0, LW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b01,2'b00,2'b00,3'b000,3'b000,1,1,0,0));
      // sw with two wait cycles
      add("sw_fetch",   0, SW, 3'b010, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b001,3'b000,0,0,0,0));
      add("sw_decode",  0, SW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b001,3'b000,0,0,0,0));
      add("sw_memadr",  0, SW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,3'b000,0,0,0,0));
      add("sw_wait1",   0, SW, 3'b010, 0, 4'h0, 0, e(0,1,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0,0,0,0));
      add("sw_wait2",   0, SW, 3'b010, 0, 4'h0, 0, e(0,1,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0,0,0,0));
      add("sw_done",    0, SW, 3'b010, 0, 4'h0, 1, e(0,1,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0,1,0,0));
      // R-type sub, then I-type with the same funct bits (add), then R-type and
      add("sub_fetch",  0, RT, 3'b000, 1, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      add("sub_decode", 0, RT, 3'b000, 1, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0,0,0));
      add("sub_execr",  0, RT, 3'b000, 1, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b010,0,0,0,0));
      add("sub_aluwb",  0, RT, 3'b000, 1, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,1,0,0));
      add("addi_fetch", 0, IT, 3'b000, 1, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      add("addi_dec",   0, IT, 3'b000, 1, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0,0,0));
      add("addi_execi", 0, IT, 3'b000, 1, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0,0,0));
      add("addi_aluwb", 0, IT, 3'b000, 1, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,1,0,0));
      add("and_fetch",  0, RT, 3'b111, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      add("and_decode", 0, RT, 3'b111, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0,0,0));
      add("and_execr",  0, RT, 3'b111, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b111,0,0,0,0));
      add("and_aluwb",  0, RT, 3'b111, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,1,0,0));
      // blt taken (N=1,V=0), bgeu not taken (C=0)
      add("blt_fetch",  0, BR, 3'b100, 0, 4'b0100, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b010,3'b000,0,0,0,0));
      add("blt_decode", 0, BR, 3'b100, 0, 4'b0100, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,3'b000,0,0,0,0));
      add("blt_branch", 0, BR, 3'b100, 0, 4'b0100, 1, e(1,0,0,0,0,2'b00,2'b10,2'b00,3'b010,3'b010,0,1,0,0));
      add("bgeu_fetch", 0, BR, 3'b111, 0, 4'b1110, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b010,3'b000,0,0,0,0));
      add("bgeu_dec",   0, BR, 3'b111, 0, 4'b1110, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,3'b000,0,0,0,0));
      add("bgeu_branch",0, BR, 3'b111, 0, 4'b1110, 1, e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,3'b010,0,1,0,0));
      // jal and lui
      add("jal_fetch",  0, JL, 3'b000, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b011,3'b000,0,0,0,0));
      add("jal_decode", 0, JL, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b011,3'b000,0,0,0,0));
      add("jal_jal",    0, JL, 3'b000, 0, 4'h0, 1, e(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,3'b000,0,0,0,0));
      add("jal_aluwb",  0, JL, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b011,3'b000,1,1,0,0));
      add("lui_fetch",  0, LU, 3'b000, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b100,3'b000,0,0,0,0));
      add("lui_decode", 0, LU, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,3'b000,0,0,0,0));
      add("lui_lui",    0, LU, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,3'b000,0,0,0,0));
      add("lui_aluwb",  0, LU, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b100,3'b000,1,1,0,0));
      // reset in the middle of a store wait, then a FETCH wait cycle
      add("swr_fetch",  0, SW, 3'b010, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b001,3'b000,0,0,0,0));
      add("swr_decode", 0, SW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b001,3'b000,0,0,0,0));
      add("swr_memadr", 0, SW, 3'b010, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,3'b000,0,0,0,0));
      add("swr_wait",   0, SW, 3'b010, 0, 4'h0, 0, e(0,1,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0,0,0,0));
      add("swr_rst",    1, SW, 3'b010, 0, 4'h0, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,3'b001,3'b000,0,0,0,0));
      add("swr_fwait",  0, SW, 3'b010, 0, 4'h0, 0, e(0,0,1,0,0,2'b10,2'b00,2'b10,3'b001,3'b000,0,0,0,0));
      // sltu encoding is illegal and halts
      add("sltu_fetch", 0, RT, 3'b011, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      add("sltu_dec",   0, RT, 3'b011, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0,1,0));
      add("sltu_halt",  0, RT, 3'b011, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,0,1));
      add("sltu_rst",   1, RT, 3'b011, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,0,1));
      // unknown opcode: pulse, then stuck in HALT until reset
      add("bad_fetch",  0, BAD, 3'b000, 0, 4'h0, 1, e(1,0,1,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));
      add("bad_decode", 0, BAD, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0,1,0));
      for (int i = 0; i < 3; i++)
         add("bad_halt",   0, BAD, 3'b000, 0, 4'hF, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,0,1));
      add("bad_rst",    1, BAD, 3'b000, 0, 4'h0, 1, e(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,0,1));
      add("post_fetch", 0, LW, 3'b010, 0, 4'h0, 0, e(0,0,1,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0,0));

      @(posedge clk); #1;
      foreach (vq[i]) begin
         rst = vq[i].rst; op = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7;
         {zero, negative, overflow, carry} = vq[i].flags; mem_ready = vq[i].rdy;
         @(negedge clk);
         n_chk++;
         if (act !== vq[i].exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h, expected %h", vq[i].name, i, act, vq[i].exp);
         end
         @(posedge clk); #1;
      end

      // lw latency with k1 FETCH waits and k2 MEMREAD waits: 5 + k1 + k2 cycles
      for (int p = 0; p < 4; p++) begin
         int k1, k2, c;
         bit seen;
         k1 = (p == 1 || p == 3) ? p : 0;
         k2 = (p >= 2) ? p + 1 : 0;
         c = 0; seen = 0;
         op = LW; funct3 = 3'b010; rst = 1'b0;
         while (!seen && c < 40) begin
            c++;
            mem_ready = !((c <= k1) || (c >= k1 + 4 && c < k1 + 4 + k2));
            @(negedge clk);
            if (instr_done) begin
               seen = 1;
               check_int("lw_wait_latency", c, k1 + k2 + 5);
               check_int("lw_wait_regwrite", int'(reg_write), 1);
            end
            @(posedge clk); #1;
         end
         if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL lw_wait_timeout: no instr_done within %0d cycles, expected at %0d", c, k1 + k2 + 5);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview: Parametrised multi-cycle successor to the single-cycle control unit for the RV32 core. It sequences each instruction through fetch/decode/execute/memory/writeback states and drives the shared-ALU, shared-memory datapath. It adds memory handshaking, the full six-way branch set, JAL/LUI support and illegal-opcode trapping. It sits between the instruction register (op/funct fields), the ALU flags and the unified instruction/data memory.

Parameters:
MEM_HANDSHAKE, 1, 1: memory accesses stall until mem_ready; 0: mem_ready ignored and treated as 1.
ENABLE_JAL, 1, 0: opcode 1101111 is treated as illegal.
ILLEGAL_HALT, 1, 1: illegal instruction enters HALT; 0: it is skipped and returns to FETCH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
op  in  7  opcode from IR.
funct3  in  3  IR[14:12].
funct7b5  in  1  IR[30].
zero, negative, overflow, carry  in  1 each  ALU flags of the current ALU result.
mem_ready  in  1  memory completes the access this cycle.
pc_write  out  1  PC load enable.
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
mem_req  out  1  memory access request.
mem_write  out  1  store strobe.
ir_write  out  1  IR/OldPC load enable.
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4.
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
alu_control  out  3  000 add, 010 sub, 001 sll, 011 slt, 100 xor, 101 srl, 110 or, 111 and.
reg_write  out  1  register file write enable.
instr_done  out  1  one-cycle pulse in the last state of each instruction.
illegal  out  1  one-cycle pulse in DECODE on an unsupported encoding.
halted  out  1  FSM is in HALT.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT.
- All outputs are decoded from state plus inputs. Signals not listed for a state are 0. imm_src is driven from op in every state.
- Reset: while rst=1, every enable/strobe (pc_write, mem_req, mem_write, ir_write, reg_write, instr_done, illegal) is forced to 0. The state becomes FETCH on the next edge. Reset has priority in every state, including mid-access and HALT.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write and pc_write are asserted only when the access completes (ready). Stay in FETCH while not ready; go to DECODE on ready.
- DECODE: alu_src_a=01, alu_src_b=01, add (computes branch target into ALUOut). Next state:
  - 0000011 or 0100011: MEMADR.
  - 0110011: EXECR.
  - 0010011: EXECI.
  - 1100011: BRANCH.
  - 1101111: JAL.
  - 0110111: LUI.
  - Anything else: illegal=1, then HALT if ILLEGAL_HALT, else FETCH with instr_done=1.
- MEMADR: alu_src_a=10, alu_src_b=01, add. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, adr_src=1. Wait for ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for ready, then FETCH with instr_done=1 on the completing cycle.
- EXECR: alu_src_a=10, alu_src_b=00. EXECI: alu_src_a=10, alu_src_b=01. Both go to ALUWB.
- ALU decode by funct3:
  - 000: sub only if op[5]=1 and funct7b5=1, else add.
  - 001 sll, 010 slt, 100 xor, 101 srl (funct7b5 ignored), 110 or, 111 and.
  - 011: add, and illegal=1 in DECODE (sltu unsupported).
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, instr_done=1, then FETCH. pc_write=taken, where taken is:
  - beq (000): zero.
  - bne (001): ~zero.
  - blt (100): negative^overflow.
  - bge (101): ~(negative^overflow).
  - bltu (110): ~carry.
  - bgeu (111): carry.
  - 010/011: never taken; illegal=1 in DECODE.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB (rd <= PC+4).
- LUI: alu_src_a=11, alu_src_b=01, add, then ALUWB.
- HALT: all enables 0, halted=1. Only rst exits HALT.
- Zero-wait cycle counts (FETCH through instr_done): load 5, store 4, R/I 4, branch 3, JAL 4, LUI 4. Each mem_ready=0 cycle adds exactly one cycle.
- With MEM_HANDSHAKE=0, mem_ready is ignored; waits never occur.

Test Plan:
1. Reset held 3 cycles, then lw (op 0000011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 in cycle 5; instr_done in cycle 5 only.
2. sw with mem_ready low for 2 cycles in MEMWRITE -> mem_req=mem_write=1, adr_src=1 held for 3 cycles. FETCH follows; no reg_write throughout.
3. R-type sub (op 0110011, funct3 000, funct7b5=1) -> alu_control=010 in EXECR. Same encoding with op 0010011 -> 000.
4. Branches: blt with negative=1, overflow=0 -> pc_write=1 in BRANCH; bgeu with carry=0 -> pc_write=0. Each completes in 3 cycles.
5. Opcode 1111111 with ILLEGAL_HALT=1 -> illegal pulse in DECODE, halted=1 forever, no enables. rst=1 -> FETCH next cycle.
6. rst asserted during MEMWRITE wait -> mem_write=0 in the same cycle, FETCH after. jal -> pc_write in JAL, reg_write in ALUWB.
